// File: rtl/pump_driver.sv
// Filter pump actuator controller: qualifies run requests against the tank level and
// enforces minimum on/off times, a run timeout and a latched dry-run interlock.
module pump_driver #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int MIN_ON_MS  = 500,
   parameter int MIN_OFF_MS = 1000,
   parameter int MAX_RUN_MS = 60000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run_req,
   input  logic       tank_empty,
   input  logic       fault_clr,
   output logic       pump_en,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      OFF_LOCK = 2'd0,
      IDLE     = 2'd1,
      RUN      = 2'd2,
      FAULT    = 2'd3
   } state_t;

   localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ / 1000 - 1);
   localparam logic [31:0] MIN_ON     = 32'(MIN_ON_MS);
   localparam logic [31:0] MIN_OFF    = 32'(MIN_OFF_MS);
   localparam logic [31:0] MAX_RUN    = 32'(MAX_RUN_MS);
   localparam logic [31:0] MS_SAT     = 32'hFFFF_FFFF;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_DRY     = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   state_t      state_q, state_d;
   logic [31:0] presc_q, presc_d;
   logic [31:0] ms_q, ms_d;
   logic        pump_en_q, pump_en_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic        tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= OFF_LOCK;
         presc_q      <= '0;
         ms_q         <= '0;
         pump_en_q    <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= CODE_NONE;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         ms_q         <= ms_d;
         pump_en_q    <= pump_en_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fault_code_d = fault_code_q;
      tick         = (presc_q == PRESC_LAST);

      case (state_q)
         OFF_LOCK: begin
            if (ms_q == MIN_OFF) state_d = IDLE;
         end
         IDLE: begin
            if (run_req && !tank_empty) state_d = RUN;
         end
         RUN: begin
            // Dry-run wins over everything, including a coincident timeout
            if (tank_empty) begin
               state_d      = FAULT;
               fault_code_d = CODE_DRY;
            end else if (ms_q == MAX_RUN) begin
               state_d      = FAULT;
               fault_code_d = CODE_TIMEOUT;
            end else if (!run_req && ms_q >= MIN_ON) begin
               state_d = OFF_LOCK;
            end
         end
         FAULT: begin
            if (fault_clr) begin
               state_d      = OFF_LOCK;
               fault_code_d = CODE_NONE;
            end
         end
         default: begin
            state_d      = OFF_LOCK;
            fault_code_d = CODE_NONE;
         end
      endcase

      // Timebase restarts on every transition so each state measures its own dwell
      if (state_d != state_q) begin
         presc_d = '0;
         ms_d    = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + 32'd1;
         ms_d    = (tick && ms_q != MS_SAT) ? ms_q + 32'd1 : ms_q;
      end

      // Outputs are registered from the next state so they change together with it
      pump_en_d = (state_d == RUN);
      fault_d   = (state_d == FAULT);
   end

   assign pump_en    = pump_en_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign state      = state_q;

endmodule

// File: doc/pump_driver.md
# pump_driver

Output-side actuator controller for the filter pump: turns a level-qualified run request into a protected pump-enable drive. It takes the debounced tank-empty level from the water-level input path and a run request from system control. It enforces minimum on-time, minimum off-time, a maximum-run timeout and a dry-run interlock. Faults latch until software clears them; `pump_en` is the only signal that reaches the pump relay/MOSFET pin.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz. Must be a multiple of 1000 and ≥ 1000.
- `MIN_ON_MS`, 500, minimum pump run time in ms. Must be ≥ 1.
- `MIN_OFF_MS`, 1000, minimum rest time in ms after any stop, fault clear or reset. Must be ≥ 1.
- `MAX_RUN_MS`, 60000, run time in ms after which a timeout fault is raised. Must satisfy `MAX_RUN_MS` > `MIN_ON_MS`.
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `run_req`  in  1  run request from control logic. Synchronous to `clk`; level-sensitive.
- `tank_empty`  in  1  debounced level, synchronous to `clk`. 1 = empty.
- `fault_clr`  in  1  single-cycle or level request to clear a latched fault.
- `pump_en`  out  1  pump drive, registered. 1 = pump on.
- `fault`  out  1  latched fault flag, registered.
- `fault_code`  out  2  fault cause, registered: 00 = none, 01 = dry-run, 10 = timeout.
- `state`  out  2  FSM state: 0 = OFF_LOCK, 1 = IDLE, 2 = RUN, 3 = FAULT.

## Operation
- **Timebase**
  - Prescaler counts 0 .. `CLK_FREQ`/1000−1 and emits a 1-cycle `tick` on its terminal count.
  - `ms_cnt` (32-bit, saturating) increments on each `tick`.
  - Both counters clear to 0 on every state transition.
- **OFF_LOCK**
  - `pump_en` = 0.
  - When `ms_cnt` == `MIN_OFF_MS`, go to IDLE. `run_req` is ignored here.
- **IDLE**
  - `pump_en` = 0.
  - If `run_req` = 1 and `tank_empty` = 0, go to RUN.
  - If `tank_empty` = 1, a request is held off. This is not a fault.
- **RUN**
  - `pump_en` = 1. Exit conditions are checked in priority order:
  1. `tank_empty` = 1 → FAULT, `fault_code` = 01. This applies immediately and overrides the minimum on-time.
  2. `ms_cnt` == `MAX_RUN_MS` → FAULT, `fault_code` = 10.
  3. `run_req` = 0 and `ms_cnt` ≥ `MIN_ON_MS` → OFF_LOCK.
  - If `run_req` drops before the minimum on-time, the pump keeps running until `ms_cnt` reaches `MIN_ON_MS`, then stops, unless `run_req` has returned to 1 by then.
- **FAULT**
  - `pump_en` = 0, `fault` = 1, `fault_code` holds the cause.
  - `fault_clr` = 1 → OFF_LOCK, with `fault` and `fault_code` cleared on the same edge.
  - `run_req` and `tank_empty` are ignored here.
- `pump_en`, `fault`, `fault_code` and `state` all update on the same edge; they never disagree for a cycle.

## Timing
- **Reset**
  - Asserting `reset` forces `state` = OFF_LOCK, `pump_en` = 0, `fault` = 0, `fault_code` = 00 and counters = 0 immediately (asynchronously), including mid-run.
  - After reset release, OFF_LOCK enforces the full `MIN_OFF_MS` before a start is possible.
- **Dwell times** (T = `CLK_FREQ`/1000 cycles per ms):
  - OFF_LOCK dwell = `MIN_OFF_MS`·T + 1 cycles.
  - Minimum RUN dwell = `MIN_ON_MS`·T + 1 cycles.
  - A timeout gives `pump_en` high for exactly `MAX_RUN_MS`·T + 1 cycles.
- **Start latency:** `run_req` sampled high in IDLE on edge N gives `pump_en` = 1 after edge N.
- **Stop latencies**
  - Dry-run: `tank_empty` sampled high on edge N gives `pump_en` = 0 after edge N, a 1-cycle latency.
  - Stop request: `run_req` low after the minimum on-time gives `pump_en` = 0 after the next edge.
- **Simultaneous events**
  - `tank_empty` and timeout in the same cycle → `fault_code` = 01.
  - `fault_clr` is only meaningful in FAULT; in other states it has no effect.

## Test plan
Parameters for all scenarios: `CLK_FREQ` = 1000 (T = 1), `MIN_ON_MS` = 3, `MIN_OFF_MS` = 5, `MAX_RUN_MS` = 10.
- **Reset/lockout:** release reset with `run_req` = 1 and `tank_empty` = 0 → `pump_en` stays 0 for 6 cycles (`state` 0 → 1), then rises 1 cycle later.
- **Min on-time:** start the pump, then pulse `run_req` high for 1 cycle only → `pump_en` high for exactly 4 cycles, then `state` = 0 for 6 cycles.
- **Dry-run:** in RUN at cycle 1, raise `tank_empty` → `pump_en` = 0 the next cycle, `fault` = 1, `fault_code` = 01, `state` = 3. Holding `run_req` = 1 keeps the pump off.
- **Timeout:** hold `run_req` = 1 with `tank_empty` = 0 → `pump_en` high for 11 cycles, then `fault` = 1 and `fault_code` = 10.
- **Fault clear:** from FAULT, pulse `fault_clr` → `fault` = 0 and `fault_code` = 00 next cycle, `state` = 0. A restart is possible only after 6 cycles.
- **Async reset mid-run:** assert `reset` between clock edges while `pump_en` = 1 → `pump_en` falls before the next `clk` edge, and all outputs return to their reset values.
